// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the muldiv_seq sequencer.
//            The NEG state exists only when MULDIV_SIGNED_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
`ifdef MULDIV_SIGNED_EN
        ST_NEG  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
// Module   : muldiv_signfix
// Purpose  : Operand magnitude and result negation helpers for signed RV32M ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  op_e                   acc_op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] mag_a,
    output logic [DATA_WIDTH-1:0] mag_b,
    output logic                  res_neg,
    input  op_e                   run_op,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] negated
);

    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [2*DATA_WIDTH-1:0] w_prod_neg;

    always_comb begin
        w_a_neg = op_a[DATA_WIDTH-1] & (acc_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        w_b_neg = op_b[DATA_WIDTH-1] & (acc_op inside {OP_MULH, OP_DIV, OP_REM});
        mag_a   = w_a_neg ? -op_a : op_a;
        mag_b   = w_b_neg ? -op_b : op_b;
        // Remainder takes the dividend's sign; everything else the sign product.
        res_neg = (acc_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

    always_comb begin
        w_prod_neg = -{hi, lo};
        case (run_op)
            OP_DIV:  negated = -lo;
            OP_REM:  negated = -hi;
            default: negated = w_prod_neg[2*DATA_WIDTH-1:DATA_WIDTH];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative RV32M multiply/divide using the shared ALU add/sub path.
//            Signed support compiled in with `define MULDIV_SIGNED_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int CNT_WIDTH      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Start,
    input  logic [2:0]                Op,
    input  logic [DATA_WIDTH-1:0]     OpA,
    input  logic [DATA_WIDTH-1:0]     OpB,
    input  logic                      Flush,
    output logic                      Busy,
    output logic                      Done,
    output logic [DATA_WIDTH-1:0]     Result,
    output logic                      ALUSel,
    output logic [DATA_WIDTH-1:0]     ALUSrcA,
    output logic [DATA_WIDTH-1:0]     ALUSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUCtrl,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic                      ALUCarry
);

    state_e                r_state, w_state_nxt;
    op_e                   r_op, w_op_in;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_acc, r_lo, r_mcand, r_result;
    logic [DATA_WIDTH-1:0] w_load_a, w_load_b, w_sh, w_acc_nxt, w_lo_nxt;
    logic [DATA_WIDTH-1:0] w_run_res, w_dz_res, w_res_val;
    logic                  w_accept, w_load_res, w_ok, w_dz, w_last, w_signed_run;

    assign w_op_in = op_e'(Op);

`ifdef MULDIV_SIGNED_EN
    logic                  r_neg, w_res_neg;
    logic [DATA_WIDTH-1:0] w_negated, w_neg_res;

    muldiv_signfix #(.DATA_WIDTH(DATA_WIDTH)) u_signfix (
        .acc_op  (w_op_in),
        .op_a    (OpA),
        .op_b    (OpB),
        .mag_a   (w_load_a),
        .mag_b   (w_load_b),
        .res_neg (w_res_neg),
        .run_op  (r_op),
        .hi      (r_acc),
        .lo      (r_lo),
        .negated (w_negated)
    );

    assign w_signed_run = r_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_neg_res    = r_neg ? w_negated : ((r_op == OP_DIV) ? r_lo : r_acc);

    always_ff @(posedge clk) begin
        if (!rst_n)        r_neg <= 1'b0;
        else if (w_accept) r_neg <= w_res_neg;
    end
`else
    assign w_load_a     = OpA;
    assign w_load_b     = OpB;
    assign w_signed_run = 1'b0;
`endif

    // acc doubles as the remainder and lo as the quotient during divides.
    assign w_sh     = {r_acc[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
    assign w_ok     = r_acc[DATA_WIDTH-1] | ~ALUCarry;
    assign w_dz     = w_op_in[2] & (OpB == '0);
    assign w_dz_res = w_op_in[1] ? OpA : '1;
    assign w_last   = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        if (r_op[2]) begin
            w_acc_nxt = w_ok ? ALUResult : w_sh;
            w_lo_nxt  = {r_lo[DATA_WIDTH-2:0], w_ok};
        end else begin
            w_acc_nxt = {ALUCarry, ALUResult[DATA_WIDTH-1:1]};
            w_lo_nxt  = {ALUResult[0], r_lo[DATA_WIDTH-1:1]};
        end
        w_run_res = (r_op inside {OP_MUL, OP_DIV, OP_DIVU}) ? w_lo_nxt : w_acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_res  = 1'b0;
        w_res_val   = w_run_res;
        Busy        = 1'b0;
        Done        = 1'b0;
        ALUSel      = 1'b0;
        ALUSrcA     = '0;
        ALUSrcB     = '0;
        ALUCtrl     = '0;
        case (r_state)
            ST_IDLE: w_accept = Start;
            ST_ITER: begin
                Busy   = 1'b1;
                ALUSel = 1'b1;
                if (r_op[2]) begin
                    ALUSrcA = w_sh;
                    ALUSrcB = r_mcand;
                    ALUCtrl = ALU_CTRL_WIDTH'(ALU_SUB);
                end else begin
                    ALUSrcA = r_acc;
                    ALUSrcB = r_lo[0] ? r_mcand : '0;
                    ALUCtrl = ALU_CTRL_WIDTH'(ALU_ADD);
                end
                if (w_last) begin
`ifdef MULDIV_SIGNED_EN
                    if (w_signed_run) begin
                        w_state_nxt = ST_NEG;
                    end else
`endif
                    begin
                        w_state_nxt = ST_DONE;
                        w_load_res  = 1'b1;
                    end
                end
            end
`ifdef MULDIV_SIGNED_EN
            ST_NEG: begin
                Busy        = 1'b1;
                w_state_nxt = ST_DONE;
                w_load_res  = 1'b1;
                w_res_val   = w_neg_res;
            end
`endif
            ST_DONE: begin
                Done        = 1'b1;
                w_state_nxt = ST_IDLE;
                w_accept    = Start;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_accept) begin
            w_state_nxt = w_dz ? ST_DONE : ST_ITER;
            w_load_res  = w_dz;
            w_res_val   = w_dz_res;
        end
        if (Flush) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_load_res  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_MUL;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
        end else if (w_accept) begin
            r_op    <= w_op_in;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_lo    <= w_load_a;
            r_mcand <= w_load_b;
        end else if (r_state == ST_ITER) begin
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_acc   <= w_acc_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          r_result <= '0;
        else if (w_load_res) r_result <= w_res_val;
    end

    assign Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq with an arithmetic RV32M model
//            and a behavioural shared ALU. Honours MULDIV_SIGNED_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Start = 1'b0;
    logic         Flush = 1'b0;
    logic [2:0]   Op = 3'd0;
    logic [W-1:0] OpA = '0;
    logic [W-1:0] OpB = '0;
    logic         Busy, Done, ALUSel, ALUCarry;
    logic [W-1:0] Result, ALUSrcA, ALUSrcB, ALUResult;
    logic [3:0]   ALUCtrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared ALU: 33-bit add, or subtract where the top bit is the borrow.
    assign {ALUCarry, ALUResult} = (ALUCtrl == 4'b0001) ? ({1'b0, ALUSrcA} - {1'b0, ALUSrcB})
                                                        : ({1'b0, ALUSrcA} + {1'b0, ALUSrcB});

    muldiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .OpA       (OpA),
        .OpB       (OpB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .ALUSel    (ALUSel),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUCtrl   (ALUCtrl),
        .ALUResult (ALUResult),
        .ALUCarry  (ALUCarry)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op_in, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2:0]  op;
        logic [63:0] pu;
        longint      ps;
        int          sa, sb;
        op = op_in;
`ifndef MULDIV_SIGNED_EN
        if (op == 3'd1 || op == 3'd2) op = 3'd3;
        else if (op == 3'd4)          op = 3'd5;
        else if (op == 3'd6)          op = 3'd7;
`endif
        sa = a;
        sb = b;
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0: return pu[31:0];
            3'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); return ps[63:32]; end
            3'd2: begin ps = longint'($signed(a)) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return 32'h8000_0000;
                return W'(sa / sb);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                return W'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (op[2] && b == 0) return 1;
`ifdef MULDIV_SIGNED_EN
        if (op inside {3'd1, 3'd2, 3'd4, 3'd6}) return W + 2;
`endif
        return W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op    = op;
        OpA   = a;
        OpB   = b;
        step();
        Start = 1'b0;
    endtask

    // Called while observing cycle T+k0 of an operation accepted at edge T.
    task automatic wait_done(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int k0);
        int k        = k0;
        int busy_n   = 0;
        int sel_n    = 0;
        int ctrl_bad = 0;
        int lat_e    = exp_lat(op, b);
        logic [W-1:0] res_e = ref_model(op, a, b);
        while (!Done && k < 100) begin
            if (Busy) busy_n++;
            if (ALUSel) begin
                sel_n++;
                if (ALUCtrl != (op[2] ? 4'd1 : 4'd0)) ctrl_bad++;
            end
            step();
            k++;
        end
        check_val({tag, ".lat"}, 64'(k), 64'(lat_e));
        check_val({tag, ".res"}, 64'(Result), 64'(res_e));
        check_val({tag, ".busy"}, 64'(busy_n), 64'(lat_e - k0));
        check_val({tag, ".sel"}, 64'(sel_n), (lat_e == 1) ? 64'd0 : 64'(W - (k0 - 1)));
        check_val({tag, ".ctrl"}, 64'(ctrl_bad), 64'd0);
        check_val({tag, ".busy_in_done"}, 64'(Busy), 64'd0);
    endtask

    logic [2:0]   d_op [17] = '{3'd0, 3'd3, 3'd0, 3'd5, 3'd7, 3'd5, 3'd7, 3'd5, 3'd7,
                                3'd4, 3'd6, 3'd4, 3'd6, 3'd1, 3'd2, 3'd4, 3'd6};
    logic [W-1:0] d_a  [17] = '{32'd7, '1, '1, 32'd100, 32'd100, '1, '1, 32'd5, 32'd5,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                                '1, '1, 32'd5, 32'hFFFF_FFF9};
    logic [W-1:0] d_b  [17] = '{32'd6, '1, '1, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000,
                                32'd0, 32'd0, 32'd2, 32'd2, '1, '1, '1, 32'd3, 32'd0, 32'd0};

    initial begin
        logic [W-1:0] held;
        int           done_n;

        repeat (3) step();
        check_val("rst.busy", 64'(Busy), 64'd0);
        check_val("rst.done", 64'(Done), 64'd0);
        check_val("rst.alusel", 64'(ALUSel), 64'd0);
        check_val("rst.srca", 64'(ALUSrcA), 64'd0);
        check_val("rst.srcb", 64'(ALUSrcB), 64'd0);
        check_val("rst.ctrl", 64'(ALUCtrl), 64'd0);
        check_val("rst.result", 64'(Result), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            start_op(d_op[i], d_a[i], d_b[i]);
            wait_done($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], 1);
            step();
            check_val($sformatf("dir%0d.hold", i), 64'(Result), 64'(ref_model(d_op[i], d_a[i], d_b[i])));
        end

        // Back-to-back: second Start lands in the Done cycle of the first.
        start_op(3'd0, 32'd7, 32'd6);
        wait_done("b2b0", 3'd0, 32'd7, 32'd6, 1);
        start_op(3'd5, 32'd100, 32'd7);
        wait_done("b2b1", 3'd5, 32'd100, 32'd7, 1);
        step();

        // Start during Busy must be ignored.
        start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) step();
        Start = 1'b1; Op = 3'd5; OpA = 32'd9; OpB = 32'd0;
        step();
        Start = 1'b0;
        wait_done("ignore", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 6);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Done || Busy) done_n++;
        end
        check_val("ignore.idle", 64'(done_n), 64'd0);

        // Flush in ITER cycle 10.
        held = Result;
        start_op(3'd0, 32'd11, 32'd13);
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check_val("flush.busy", 64'(Busy), 64'd0);
        check_val("flush.alusel", 64'(ALUSel), 64'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) done_n++;
            step();
        end
        check_val("flush.nodone", 64'(done_n), 64'd0);
        check_val("flush.result", 64'(Result), 64'(held));

        // Flush wins over a simultaneous Start.
        Start = 1'b1; Flush = 1'b1; Op = 3'd0; OpA = 32'd3; OpB = 32'd4;
        step();
        Start = 1'b0; Flush = 1'b0;
        check_val("flushstart.busy", 64'(Busy), 64'd0);
        step();
        check_val("flushstart.done", 64'(Done), 64'd0);

        // Reset mid-operation clears Result.
        start_op(3'd0, 32'd7, 32'd6);
        wait_done("prerst", 3'd0, 32'd7, 32'd6, 1);
        start_op(3'd5, 32'd1000, 32'd3);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("midrst.busy", 64'(Busy), 64'd0);
        check_val("midrst.result", 64'(Result), 64'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            start_op(op, a, b);
            wait_done($sformatf("rnd%0d_op%0d_%0h_%0h", i, op, a, b), op, a, b, 1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer that borrows the shared ALU's add/subtract path instead of instantiating its own wide adder. It sits beside the execute stage. When a request is accepted it takes the ALU through a mux (ALUSel), runs one add or subtract per cycle for DATA_WIDTH cycles, then returns a registered result with a one-cycle Done pulse. The core stalls while Busy is high.

## Interface
- DATA_WIDTH, 32: operand and result width.
- ALU_CTRL_WIDTH, 4: width of the ALU control code.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: iteration counter width.
- clk  in  1  clock.
- rst_n  in  1  reset. **Synchronous, active-low.**
- Start  in  1  request strobe. Accepted only while Busy=0.
- Op  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OpA, OpB  in  DATA_WIDTH  rs1/rs2 operands, sampled on accept.
- Flush  in  1  abort any operation in flight.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; Result is valid in that cycle.
- Result  out  DATA_WIDTH  registered; held until the next Done.
- ALUSel  out  1  block owns the ALU.
- ALUSrcA, ALUSrcB  out  DATA_WIDTH  ALU operand drives.
- ALUCtrl  out  ALU_CTRL_WIDTH  0000 add, 0001 subtract.
- ALUResult  in  DATA_WIDTH  ALU sum or difference.
- ALUCarry  in  1  ALU bit DATA_WIDTH. For subtract, 1 means borrow.

## Operation
- States:
  - IDLE: on Start, go to ITER, or to DONE on a divide by zero. Load registers; clear the counter.
  - ITER: exits to NEG (signed op with the macro enabled) or DONE when the counter reaches DATA_WIDTH-1.
  - NEG: always goes to DONE.
  - DONE: asserts Done, Busy=0. Goes to IDLE, or accepts a new Start (back-to-back) as IDLE would.
- Multiply: acc=0, lo=multiplier, mcand=multiplicand.
  - Each ITER cycle: ALUSrcA=acc, ALUSrcB = lo[0] ? mcand : 0, ALUCtrl=add.
  - Then acc <= {ALUCarry, ALUResult[W-1:1]} and lo <= {ALUResult[0], lo[W-1:1]}.
  - MUL returns lo. MULH, MULHSU and MULHU return acc.
- Divide (restoring): rem=0, quo=dividend.
  - sh = {rem[W-2:0], quo[W-1]}. ALUSrcA=sh, ALUSrcB=divisor, ALUCtrl=sub.
  - ok = rem[W-1] | ~ALUCarry.
  - rem <= ok ? ALUResult : sh, and quo <= {quo[W-2:0], ok}.
  - DIV/DIVU return quo. REM/REMU return rem.
- Divide by zero is detected on accept and skips ITER:
  - DIV/DIVU return all ones.
  - REM/REMU return OpA.
- Outside ITER: ALUSel=0 and ALUSrcA, ALUSrcB, ALUCtrl are 0.
- Start while Busy=1 is ignored (no queueing).
- Flush in any state: IDLE on the next edge, no Done, Result unchanged. Flush wins over a simultaneous Start.
- Reset: state IDLE. Busy, Done, ALUSel, ALUSrcA/B, ALUCtrl, Result, counter and all internal registers are 0.

## Timing
- Start is accepted at edge T. Busy=1 and ALUSel=1 from T+1.
- ITER occupies cycles T+1..T+W (W=DATA_WIDTH).
- Done and Result appear in cycle T+W+1 for unsigned ops, and in T+W+2 for signed ops with the macro enabled.
- Divide by zero: Done at T+1.
- A Start asserted in the Done cycle gives Busy continuously high from the next cycle.
- Reset mid-operation behaves like Flush, and additionally clears Result.

## Configuration
- MULDIV_SIGNED_EN defined (signed support compiled in):
  - On accept, operands are replaced by their absolute values: OpA for MULH, DIV and REM; OpB for MULH, DIV and REM; OpA only for MULHSU.
  - Negation applies in NEG, using local two's complement on {acc,lo}, quo or rem:
    - product: when operand signs differ (MULHSU: when OpA < 0);
    - quotient: when signs differ;
    - remainder: when the dividend is negative.
  - 0x80000000 / -1 yields 0x80000000, with REM 0.
  - Divide by zero: results as above, no negation.
- MULDIV_SIGNED_EN undefined:
  - MULH and MULHSU execute as MULHU; DIV as DIVU; REM as REMU.
  - The NEG state is absent.

## Structure
- muldiv_pkg holds:
  - the op enum (funct3 values);
  - the state enum;
  - ALU_ADD=4'b0000 and ALU_SUB=4'b0001.
- Sub-module muldiv_signfix (abs/negate helpers) is instantiated only under MULDIV_SIGNED_EN. Everything else is a single module.

## Test plan
1. MUL 7×6 → Result 42, Done at T+33, ALUCtrl=0000 and ALUSel=1 for exactly 32 cycles.
2. 0xFFFFFFFF×0xFFFFFFFF → MULHU 0xFFFFFFFE; MUL 0x00000001.
3. DIVU/REMU operand cases:
   - 100/7 → quotient 14, remainder 2.
   - 0xFFFFFFFF/0x80000000 → quotient 1, remainder 0x7FFFFFFF (exercises the rem[W-1] path).
4. DIVU 5/0 → 0xFFFFFFFF with Done at T+1. REMU 5/0 → 5.
5. Flush, Start-while-busy and back-to-back:
   - Flush in ITER cycle 10 → no Done, Busy=0 next cycle, Result unchanged.
   - Start during Busy → ignored.
   - Start in the Done cycle → accepted.
6. Signed behaviour, by build:
   - Macro on: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF, DIV 0x80000000/0xFFFFFFFF → 0x80000000, MULH −1×−1 → 0, each with Done at T+34.
   - Macro off: DIV 0xFFFFFFF9/2 → 0x7FFFFFFC.
